// File: rtl/tmr_scrub_pkg.sv
// Shared types and constants for the triplicated-register scrubber.
// Replica indices double as the injMask and errDomain bit positions.
package tmr_scrub_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } state_t;

  localparam int NUM_REPLICAS = 3;

  localparam int INJ_A = 0;
  localparam int INJ_B = 1;
  localparam int INJ_C = 2;

endpackage

// File: rtl/majorityVoter.sv
// Single-bit 2-of-3 majority gate.
module majorityVoter (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_y
);

  assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/tmr_fanout_scrubber.sv
// Triplicates an input word into three registers, votes them bitwise, scrubs
// divergent replicas back to the vote and reports the affected replicas.
module tmr_fanout_scrubber
  import tmr_scrub_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [WIDTH-1:0]        inData,
  input  logic                    inValid,
  output logic                    inReady,
  output logic [WIDTH-1:0]        outA,
  output logic [WIDTH-1:0]        outB,
  output logic [WIDTH-1:0]        outC,
  output logic [WIDTH-1:0]        voted,
  output logic                    errValid,
  output logic [NUM_REPLICAS-1:0] errDomain,
  input  logic                    errReady,
  output logic [CNT_WIDTH-1:0]    errCount,
  input  logic                    clrCount,
  input  logic                    injEn,
  input  logic [NUM_REPLICAS-1:0] injMask,
  input  logic [WIDTH-1:0]        injData
);

  state_t r_state;
  state_t w_state_next;

  logic [NUM_REPLICAS-1:0][WIDTH-1:0] r_rep;
  logic [NUM_REPLICAS-1:0][WIDTH-1:0] w_rep_next;
  logic [NUM_REPLICAS-1:0]            w_diff;
  logic [NUM_REPLICAS-1:0]            r_domain;
  logic [NUM_REPLICAS-1:0]            w_domain_next;
  logic [CNT_WIDTH-1:0]               r_count;

  logic w_write;
  logic w_inject;
  logic w_scrub;
  logic w_accept;

  // Handshake outputs depend on state only, never on the same-cycle inputs.
  assign inReady  = (r_state == IDLE);
  assign errValid = (r_state == REPORT);

  assign w_write  = inValid & inReady;
  assign w_inject = injEn & ~w_write;
  assign w_scrub  = (|w_diff) & ~w_write & ~w_inject;
  assign w_accept = errValid & errReady;

  genvar gi;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_vote
      majorityVoter u_vote (
        .i_a (r_rep[INJ_A][gi]),
        .i_b (r_rep[INJ_B][gi]),
        .i_c (r_rep[INJ_C][gi]),
        .o_y (voted[gi])
      );
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_REPLICAS; gi++) begin : g_rep
      assign w_diff[gi] = (r_rep[gi] != voted);

      // Unmasked replicas keep their value on an inject edge; no scrub then.
      assign w_rep_next[gi] = w_write                   ? inData  :
                              (w_inject && injMask[gi]) ? injData :
                              w_inject                  ? r_rep[gi] :
                              w_scrub                   ? voted   :
                                                          r_rep[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rep <= '0;
    end else begin
      r_rep <= w_rep_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_domain <= '0;
    end else begin
      r_state  <= w_state_next;
      r_domain <= w_domain_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_domain_next = r_domain;
    case (r_state)
      IDLE: begin
        if (w_scrub) begin
          w_state_next  = REPORT;
          w_domain_next = w_diff;
        end
      end
      REPORT: begin
        // An accepted report restarts the sticky set from this edge's scrub.
        if (w_accept) begin
          if (w_scrub) begin
            w_domain_next = w_diff;
          end else begin
            w_state_next  = IDLE;
            w_domain_next = '0;
          end
        end else if (w_scrub) begin
          w_domain_next = r_domain | w_diff;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_domain_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (clrCount) begin
      r_count <= '0;
    end else if (w_scrub && (r_count != {CNT_WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign outA      = r_rep[INJ_A];
  assign outB      = r_rep[INJ_B];
  assign outC      = r_rep[INJ_C];
  assign errDomain = r_domain;
  assign errCount  = r_count;

endmodule

// File: tb/tb_tmr_fanout_scrubber.sv
// Bench for tmr_fanout_scrubber: a vector table run through a scoreboard
// queue on an 8-bit-counter and a 2-bit-counter instance sharing stimulus.
module tb_tmr_fanout_scrubber;

  logic       clk;
  logic       rstn;
  logic [7:0] inData;
  logic       inValid;
  logic       errReady;
  logic       clrCount;
  logic       injEn;
  logic [2:0] injMask;
  logic [7:0] injData;

  logic       inReady_a, inReady_b;
  logic [7:0] outA_a, outB_a, outC_a, voted_a;
  logic [7:0] outA_b, outB_b, outC_b, voted_b;
  logic       errValid_a, errValid_b;
  logic [2:0] errDomain_a, errDomain_b;
  logic [7:0] errCount_a;
  logic [1:0] errCount_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       inj_en;
    logic [2:0] inj_mask;
    logic [7:0] inj_data;
    logic       err_ready;
    logic       clr;
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic [7:0] e_c;
    logic [7:0] e_v;
    logic       e_ev;
    logic [2:0] e_dom;
    logic [7:0] e_cnt8;
    logic [1:0] e_cnt2;
    logic       e_ir;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];
  vec_t exp_q [$];

  tmr_fanout_scrubber #(.WIDTH(8), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rstn(rstn), .inData(inData), .inValid(inValid), .inReady(inReady_a),
    .outA(outA_a), .outB(outB_a), .outC(outC_a), .voted(voted_a),
    .errValid(errValid_a), .errDomain(errDomain_a), .errReady(errReady),
    .errCount(errCount_a), .clrCount(clrCount),
    .injEn(injEn), .injMask(injMask), .injData(injData)
  );

  tmr_fanout_scrubber #(.WIDTH(8), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rstn(rstn), .inData(inData), .inValid(inValid), .inReady(inReady_b),
    .outA(outA_b), .outB(outB_b), .outC(outC_b), .voted(voted_b),
    .errValid(errValid_b), .errDomain(errDomain_b), .errReady(errReady),
    .errCount(errCount_b), .clrCount(clrCount),
    .injEn(injEn), .injMask(injMask), .injData(injData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic iv, input logic [7:0] id, input logic ie, input logic [2:0] im,
    input logic [7:0] idt, input logic er, input logic cl,
    input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] v,
    input logic ev, input logic [2:0] dom, input logic [7:0] c8, input logic [1:0] c2,
    input logic ir);
    vec_t r;
    r.in_valid = iv;  r.in_data = id;  r.inj_en = ie;  r.inj_mask = im;
    r.inj_data = idt; r.err_ready = er; r.clr = cl;
    r.e_a = a; r.e_b = b; r.e_c = c; r.e_v = v;
    r.e_ev = ev; r.e_dom = dom; r.e_cnt8 = c8; r.e_cnt2 = c2; r.e_ir = ir;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    inValid  = v.in_valid;
    inData   = v.in_data;
    injEn    = v.inj_en;
    injMask  = v.inj_mask;
    injData  = v.inj_data;
    errReady = v.err_ready;
    clrCount = v.clr;
  endtask

  task automatic compare(input string tag, input vec_t e);
    chk({tag, " outA"},      32'(outA_a),      32'(e.e_a));
    chk({tag, " outB"},      32'(outB_a),      32'(e.e_b));
    chk({tag, " outC"},      32'(outC_a),      32'(e.e_c));
    chk({tag, " voted"},     32'(voted_a),     32'(e.e_v));
    chk({tag, " errValid"},  32'(errValid_a),  32'(e.e_ev));
    chk({tag, " errDomain"}, 32'(errDomain_a), 32'(e.e_dom));
    chk({tag, " errCount"},  32'(errCount_a),  32'(e.e_cnt8));
    chk({tag, " inReady"},   32'(inReady_a),   32'(e.e_ir));
    chk({tag, " b.voted"},   32'({outA_b, outB_b, outC_b, voted_b}),
                             32'({e.e_a, e.e_b, e.e_c, e.e_v}));
    chk({tag, " b.status"},  32'({errValid_b, errDomain_b, inReady_b}),
                             32'({e.e_ev, e.e_dom, e.e_ir}));
    chk({tag, " b.errCount"}, 32'(errCount_b), 32'(e.e_cnt2));
  endtask

  // Drive one vector at the falling edge, check after the next rising edge.
  task automatic run_vec(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      compare(tag, e);
      $display("%s: A=%h B=%h C=%h voted=%h errValid=%0d errDomain=%b errCount=%0d/%0d inReady=%0d",
               tag, outA_a, outB_a, outC_a, voted_a, errValid_a, errDomain_a,
               errCount_a, errCount_b, inReady_a);
    end
  endtask

  initial begin
    vec_t rst_exp;
    rstn     = 1'b0;
    inValid  = 1'b0;
    inData   = 8'h00;
    injEn    = 1'b0;
    injMask  = 3'b000;
    injData  = 8'h00;
    errReady = 1'b0;
    clrCount = 1'b0;

    //          iv    id     ie    im      idt    er    cl    A      B      C      V      ev    dom     c8     c2     ir
    vecs[0]  = mk(1'b1, 8'hA5, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0, 3'b000, 8'd0, 2'd0, 1'b1);
    vecs[1]  = mk(1'b0, 8'h00, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b0, 3'b000, 8'd0, 2'd0, 1'b1);
    vecs[2]  = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b1, 3'b010, 8'd1, 2'd1, 1'b0);
    vecs[3]  = mk(1'b0, 8'h00, 1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'hA5, 8'hA5, 8'hA5, 1'b1, 3'b010, 8'd1, 2'd1, 1'b0);
    vecs[4]  = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b1, 3'b011, 8'd2, 2'd2, 1'b0);
    vecs[5]  = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0, 3'b000, 8'd2, 2'd2, 1'b1);
    vecs[6]  = mk(1'b1, 8'hF0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 1'b0, 3'b000, 8'd2, 2'd2, 1'b1);
    vecs[7]  = mk(1'b1, 8'h3C, 1'b1, 3'b001, 8'h0F, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0, 3'b000, 8'd2, 2'd2, 1'b1);
    vecs[8]  = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0, 3'b000, 8'd2, 2'd2, 1'b1);
    vecs[9]  = mk(1'b0, 8'h00, 1'b1, 3'b001, 8'h3D, 1'b0, 1'b0, 8'h3D, 8'h3C, 8'h3C, 8'h3C, 1'b0, 3'b000, 8'd2, 2'd2, 1'b1);
    vecs[10] = mk(1'b0, 8'h00, 1'b1, 3'b010, 8'h38, 1'b0, 1'b0, 8'h3D, 8'h38, 8'h3C, 8'h3C, 1'b0, 3'b000, 8'd2, 2'd2, 1'b1);
    vecs[11] = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b1, 3'b011, 8'd3, 2'd3, 1'b0);
    vecs[12] = mk(1'b0, 8'h00, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h00, 8'h3C, 1'b1, 3'b011, 8'd3, 2'd3, 1'b0);
    vecs[13] = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b1, 3'b111, 8'd4, 2'd3, 1'b0);
    vecs[14] = mk(1'b0, 8'h00, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h3C, 8'h3C, 1'b1, 3'b111, 8'd4, 2'd3, 1'b0);
    vecs[15] = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b1, 3'b001, 8'd5, 2'd3, 1'b0);
    vecs[16] = mk(1'b0, 8'h00, 1'b1, 3'b010, 8'hFF, 1'b0, 1'b0, 8'h3C, 8'hFF, 8'h3C, 8'h3C, 1'b1, 3'b001, 8'd5, 2'd3, 1'b0);
    vecs[17] = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b1, 3'b011, 8'd0, 2'd0, 1'b0);
    vecs[18] = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0, 3'b000, 8'd0, 2'd0, 1'b1);
    vecs[19] = mk(1'b0, 8'h00, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h00, 8'h3C, 1'b0, 3'b000, 8'd0, 2'd0, 1'b1);
    vecs[20] = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b1, 3'b100, 8'd1, 2'd1, 1'b0);

    // Reset state, sampled at a falling edge while rstn is low.
    rst_exp = mk(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'b000, 8'd0, 2'd0, 1'b1);
    repeat (2) @(negedge clk);
    compare("reset", rst_exp);
    $display("reset: A=%h voted=%h errValid=%0d errCount=%0d inReady=%0d",
             outA_a, voted_a, errValid_a, errCount_a, inReady_a);
    rstn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of a pending report (vec20 left REPORT).
    #2;
    rstn = 1'b0;
    #1;
    compare("async_rst", rst_exp);
    $display("async_rst: A=%h B=%h C=%h errValid=%0d errDomain=%b errCount=%0d inReady=%0d",
             outA_a, outB_a, outC_a, errValid_a, errDomain_a, errCount_a, inReady_a);
    repeat (2) @(posedge clk);
    #1;
    compare("rst_hold", rst_exp);

    // Release at a falling edge; the first rising edge must accept a write.
    @(negedge clk);
    rstn = 1'b1;
    #1;
    compare("rst_release", rst_exp);
    run_vec("post_rst_write",
            mk(1'b1, 8'h5A, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h5A, 8'h5A,
               1'b0, 3'b000, 8'd0, 2'd0, 1'b1));

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tmr_fanout_scrubber.md
TMR_FANOUT_SCRUBBER -- requirements
Module: tmr_fanout_scrubber

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width of the stored word and of each replica.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8: width of the saturating error counter.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port inData, input, WIDTH: the single-copy word to be triplicated.
REQ-006 The block SHALL have port inValid, input, 1: inData valid.
REQ-007 The block SHALL have port inReady, output, 1: the block accepts inData this cycle.
REQ-008 The block SHALL have ports outA, outB and outC, output, WIDTH each: the three registered replicas.
REQ-009 The block SHALL have port voted, output, WIDTH: the bitwise 2-of-3 majority of outA, outB and outC (combinational).
REQ-010 The block SHALL have port errValid, output, 1: an error report is pending.
REQ-011 The block SHALL have port errDomain, output, 3: the sticky one-hot-or-multi-hot set of replicas found divergent ({C,B,A}).
REQ-012 The block SHALL have port errReady, input, 1: the consumer accepts the error report.
REQ-013 The block SHALL have port errCount, output, CNT_WIDTH: the saturating count of scrub corrections.
REQ-014 The block SHALL have port clrCount, input, 1: synchronous clear of errCount.
REQ-015 The block SHALL have ports injEn (input, 1), injMask (input, 3) and injData (input, WIDTH): the test fault-injection port.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and REPORT.
REQ-017 inReady SHALL be 1 in IDLE and 0 in REPORT.
REQ-018 On a write (inValid and inReady at an edge), all three replicas SHALL load inData; the new value is visible on outA/B/C and voted the next cycle (latency 1).
REQ-019 When injEn=1 with no write at an edge, each replica whose injMask bit is set SHALL load injData; there is no error report in that cycle.
REQ-020 Mismatch SHALL be defined as any replica differing from voted, with per-replica flag d[i] = (out_i != voted).
REQ-021 On a mismatch with no write and no inject at an edge, all three replicas SHALL load voted (scrub), errCount SHALL increment by 1 (saturating at all-ones), and errDomain SHALL be ORed with d.
REQ-022 When a scrub occurs in IDLE, the FSM SHALL move to REPORT and assert errValid.
REQ-023 Priority per edge SHALL be write > inject > scrub; a mismatch coinciding with a write or an inject SHALL be discarded, with no count and no report.
REQ-024 In REPORT, errValid SHALL remain 1 and errDomain SHALL be held until errValid and errReady are both high at an edge.
REQ-025 In REPORT, further mismatches SHALL still be scrubbed and counted, with errDomain accumulating (sticky).
REQ-026 On an accepting edge (errValid and errReady), the FSM SHALL return to IDLE and clear errDomain to 0; if a scrub occurs on the same edge, the FSM SHALL remain in REPORT and errDomain SHALL equal the new d.
REQ-027 clrCount SHALL have priority over increment: clrCount=1 yields errCount=0 even if a scrub occurs on the same edge.
REQ-028 Voting SHALL be bitwise, so a word with different bits wrong in different replicas is still corrected, with multi-hot errDomain.
REQ-029 The block SHALL have no combinational path from inValid to inReady, or from errReady to errValid.

Reset
REQ-030 While rstn=0, the block SHALL asynchronously force: outA=outB=outC=0, errValid=0, errDomain=0, errCount=0, FSM=IDLE.
REQ-031 Reset asserted mid-REPORT SHALL drop the pending report without handshake.
REQ-032 Reset release SHALL be synchronized externally; the first write is accepted on the first edge after rstn rises.

Structure
REQ-033 The state enum (IDLE, REPORT) and the injMask bit positions SHALL live in package tmr_scrub_pkg.
REQ-034 Voting SHALL instantiate the existing majorityVoter sub-module once per bit (WIDTH instances via generate); no other sub-modules.

Verification
REQ-035 The bench SHALL check: reset, then write 0xA5 -> next cycle outA/B/C=voted=0xA5, errValid=0, errCount=0.
REQ-036 The bench SHALL check: after 0xA5, injEn with injMask=3'b010 and injData=0x00 -> outB=0x00, voted=0xA5; next edge all replicas=0xA5, errValid=1, errDomain=3'b010, errCount=1, inReady=0.
REQ-037 The bench SHALL check: while errValid=1 with errReady=0, inject 3'b001/0xFF -> scrub, errCount=2, errDomain=3'b011; then errReady=1 -> IDLE, errDomain=0, inReady=1.
REQ-038 The bench SHALL check: inject with injMask=3'b001 and injData=0x0F on 0xF0 coincident with a new write 0x3C -> all replicas=0x3C, no report, count unchanged.
REQ-039 The bench SHALL check: with CNT_WIDTH=2, four scrubs -> errCount saturates at 3; scrub and clrCount on the same edge -> errCount=0.
REQ-040 The bench SHALL check: rstn pulled low mid-REPORT -> outputs immediately 0, errValid=0, and the block is in IDLE after release.
